// File: rtl/ff_bank_universal_pkg.sv
//------------------------------------------------------------------------------
// Module   : ff_bank_universal_pkg
// Brief    : Mode codes shared by the universal flip-flop bank and its bit cell.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ff_bank_universal_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_D    = 3'd1;
  localparam mode_t MODE_T    = 3'd2;
  localparam mode_t MODE_JK   = 3'd3;
  localparam mode_t MODE_SR   = 3'd4;
  localparam mode_t MODE_CN   = 3'd5;
  localparam mode_t MODE_SHL  = 3'd6;
  localparam mode_t MODE_SHR  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ff_cell.sv
//------------------------------------------------------------------------------
// Module   : ff_cell
// Brief    : Next-state logic for one bit of the universal flip-flop bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ff_cell
  import ff_bank_universal_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q_cur,
  input  logic       shift_in,
  output logic       q_next,
  output logic       sr_conflict
);

  always_comb begin
    q_next      = q_cur;
    sr_conflict = 1'b0;
    case (mode)
      MODE_HOLD: q_next = q_cur;
      MODE_D:    q_next = a;
      MODE_T:    q_next = q_cur ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q_cur;
          default: q_next = q_cur;
        endcase
      end
      MODE_SR: begin
        // s=r=1 holds the bit; the conflict is reported upward instead
        if (a && !b)      q_next = 1'b1;
        else if (!a && b) q_next = 1'b0;
        sr_conflict = a & b;
      end
      MODE_CN: begin
        if (b) q_next = a ? ~q_cur : 1'b0;
      end
      MODE_SHL:  q_next = shift_in;
      MODE_SHR:  q_next = shift_in;
      default:   q_next = q_cur;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ff_bank_universal.sv
//------------------------------------------------------------------------------
// Module   : ff_bank_universal
// Brief    : WIDTH-bit mode-selectable flip-flop bank with SR-conflict flag and
//            saturating change counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ff_bank_universal
  import ff_bank_universal_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_chg_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conflict;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shift_in;

  // Serial-in bits enter at the ends: a[0] for left shift, a[WIDTH-1] for right
  assign w_shl      = {r_q[WIDTH-2:0], a[0]};
  assign w_shr      = {a[WIDTH-1], r_q[WIDTH-1:1]};
  assign w_shift_in = (mode == MODE_SHR) ? w_shr : w_shl;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    ff_cell u_cell (
      .mode        (mode),
      .a           (a[gi]),
      .b           (b[gi]),
      .q_cur       (r_q[gi]),
      .shift_in    (w_shift_in[gi]),
      .q_next      (w_q_next[gi]),
      .sr_conflict (w_conflict[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= RESET_VAL;
      r_sr_err  <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      if (en) r_q <= w_q_next;

      if (en && (|w_conflict)) r_sr_err <= 1'b1;
      else if (err_clr)        r_sr_err <= 1'b0;

      if (en && (w_q_next != r_q) && (r_chg_cnt != c_CNT_MAX))
        r_chg_cnt <= r_chg_cnt + 1'b1;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign sr_err  = r_sr_err;
  assign chg_cnt = r_chg_cnt;

endmodule

`default_nettype wire
